// File: rtl/uart_reg_bridge.sv
// Byte-level command responder: parses 'W'/'R' frames from the UART receiver,
// performs single 8-bit register bus accesses and returns one reply byte per frame.
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TO_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_clr_o,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_busy_i,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  output logic       bus_we_o,
  output logic       bus_re_o,
  input  logic [7:0] bus_rdata_i,
  output logic       err_o
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_RDWAIT, S_TXGO, S_TXHOLD, S_TXWAIT
  } state_e;

  state_e          state_q;
  logic            guard_q;
  logic            is_read_q;
  logic [1:0]      phase_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            rx_clr_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic [7:0]      bus_addr_q;
  logic [7:0]      bus_wdata_q;
  logic            bus_we_q;
  logic            bus_re_q;
  logic            err_q;
  logic            consume;

  // The UART drops has_byte one cycle after clr_hb, so a just-cleared byte is masked.
  assign consume = rx_valid_i && !guard_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      guard_q     <= 1'b0;
      is_read_q   <= 1'b0;
      phase_q     <= 2'd0;
      to_cnt_q    <= '0;
      rx_clr_q    <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      bus_addr_q  <= 8'h00;
      bus_wdata_q <= 8'h00;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_clr_q   <= 1'b0;
      tx_start_q <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_re_q   <= 1'b0;
      guard_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          to_cnt_q <= '0;
          if (consume) begin
            rx_clr_q <= 1'b1;
            guard_q  <= 1'b1;
            if (rx_data_i == CMD_WR) begin
              is_read_q <= 1'b0;
              state_q   <= S_ADDR;
            end else if (rx_data_i == CMD_RD) begin
              is_read_q <= 1'b1;
              state_q   <= S_ADDR;
            end else begin
              tx_data_q <= NAK;
              err_q     <= 1'b1;
              state_q   <= S_TXGO;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (consume) begin
            rx_clr_q <= 1'b1;
            guard_q  <= 1'b1;
            to_cnt_q <= '0;
            if (state_q == S_ADDR) begin
              bus_addr_q <= rx_data_i;
              phase_q    <= 2'd0;
              state_q    <= is_read_q ? S_RDWAIT : S_DATA;
            end else begin
              bus_wdata_q <= rx_data_i;
              bus_we_q    <= 1'b1;
              tx_data_q   <= ACK;
              state_q     <= S_TXGO;
            end
          end else if (to_cnt_q == TO_LAST) begin
            // Partial frame abandoned by the host: drop silently, flag error.
            to_cnt_q <= '0;
            err_q    <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_RDWAIT: begin
          // Phase 0 issues bus_re, phase 2 samples the data returned after it.
          case (phase_q)
            2'd0: begin
              bus_re_q <= 1'b1;
              phase_q  <= 2'd1;
            end
            2'd1: phase_q <= 2'd2;
            default: begin
              tx_data_q <= bus_rdata_i;
              state_q   <= S_TXGO;
            end
          endcase
        end
        S_TXGO: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            phase_q    <= 2'd0;
            state_q    <= S_TXHOLD;
          end
        end
        S_TXHOLD: begin
          // Busy is not yet trustworthy while the UART registers the start.
          if (phase_q == 2'd1) begin
            state_q <= S_TXWAIT;
          end else begin
            phase_q <= 2'd1;
          end
        end
        S_TXWAIT: begin
          if (!tx_busy_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_clr_o    = rx_clr_q;
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_we_o    = bus_we_q;
  assign bus_re_o    = bus_re_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: behavioural UART/register-bank environment,
// frame-level reference model feeding expected queues, decoupled negedge monitor.
module tb_uart_reg_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_clr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata = 8'h00;
  logic       err;

  typedef struct packed {
    logic       is_we;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_ev_t;

  logic [7:0] host_q[$];
  logic [7:0] exp_reply[$];
  bus_ev_t    exp_bus[$];
  logic [7:0] ref_regs[256];
  logic [7:0] bank[256];
  logic       bank_init = 1'b0;
  logic       exp_err = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pushed = 0;
  int         n_clr = 0;
  int         busy_cnt = 0;
  logic [7:0] tx_lat = 8'h00;

  always #5 clk = ~clk;

  uart_reg_bridge #(.TIMEOUT(50), .TO_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_clr_o   (rx_clr),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .tx_busy_i  (tx_busy),
    .bus_addr_o (bus_addr),
    .bus_wdata_o(bus_wdata),
    .bus_we_o   (bus_we),
    .bus_re_o   (bus_re),
    .bus_rdata_i(bus_rdata),
    .err_o      (err)
  );

  function automatic logic [7:0] init_val(input int i);
    return (i == 8'h34) ? 8'h5C : 8'((i * 7) + 3);
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // UART receiver: delivers host bytes one at a time, clears one cycle after clr_hb.
  always @(posedge clk) begin
    if (rx_clr) begin
      n_clr    <= n_clr + 1;
      rx_valid <= 1'b0;
    end else if (!rx_valid && host_q.size() > 0 && $urandom_range(1, 0) == 1) begin
      rx_data  <= host_q.pop_front();
      rx_valid <= 1'b1;
    end
  end

  // UART transmitter: busy for 40 cycles (10 bits at divisor 4), asserted after start.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (tx_start && busy_cnt == 0) begin
      busy_cnt <= 40;
      tx_lat   <= tx_data;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Register bank: read data is returned the cycle after bus_re.
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 256; i++) bank[i] <= init_val(i);
      bank_init <= 1'b1;
    end else begin
      if (bus_we) bank[bus_addr] <= bus_wdata;
      if (bus_re) bus_rdata <= bank[bus_addr];
    end
  end

  // Monitor: pops expectations whenever the DUT presents a reply or bus strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
        if (exp_reply.size() == 0) chk("unexpected_tx_start", 32'(exp_reply.size()), 32'd1);
        else chk("reply_byte", 32'(tx_data), 32'(exp_reply.pop_front()));
      end
      if (bus_we || bus_re) begin
        if (exp_bus.size() == 0) begin
          chk("unexpected_bus_strobe", 32'(exp_bus.size()), 32'd1);
        end else begin
          bus_ev_t ev;
          ev = exp_bus.pop_front();
          chk("bus_kind_we", 32'(bus_we), 32'(ev.is_we));
          chk("bus_kind_re", 32'(bus_re), 32'(!ev.is_we));
          chk("bus_addr", 32'(bus_addr), 32'(ev.addr));
          if (ev.is_we) begin
            chk("bus_wdata", 32'(bus_wdata), 32'(ev.data));
            chk("we_with_rx_clr", 32'(rx_clr), 32'd1);
          end
        end
      end
      if (tx_busy) chk("tx_data_stable", 32'(tx_data), 32'(tx_lat));
    end
  end

  task automatic push_byte(input logic [7:0] b);
    host_q.push_back(b);
    n_pushed++;
  endtask

  task automatic issue_write(input logic [7:0] a, input logic [7:0] d);
    push_byte(8'h57); push_byte(a); push_byte(d);
    exp_bus.push_back('{is_we: 1'b1, addr: a, data: d});
    ref_regs[a] = d;
    exp_reply.push_back(8'h06);
  endtask

  task automatic issue_read(input logic [7:0] a);
    push_byte(8'h52); push_byte(a);
    exp_bus.push_back('{is_we: 1'b0, addr: a, data: 8'h00});
    exp_reply.push_back(ref_regs[a]);
  endtask

  task automatic issue_bad(input logic [7:0] c);
    push_byte(c);
    exp_reply.push_back(8'h15);
    exp_err = 1'b1;
  endtask

  task automatic wait_rx_empty();
    int k = 0;
    while (!(host_q.size() == 0 && !rx_valid) && k < 2000) begin
      @(posedge clk); k++;
    end
    chk("rx_drained_in_time", 32'(k < 2000), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (!(host_q.size() == 0 && !rx_valid && exp_reply.size() == 0 &&
             exp_bus.size() == 0 && !tx_busy) && k < budget) begin
      @(posedge clk); k++;
    end
    chk("drain_in_time", 32'(k < budget), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_rx_clr", 32'(rx_clr), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_re", 32'(bus_re), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    for (int i = 0; i < 256; i++) ref_regs[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values();
    @(negedge clk) rst = 1'b0;

    issue_write(8'h12, 8'hA5);
    wait_drain(2000);
    chk("err_after_write", 32'(err), 32'(exp_err));
    chk("bank_written", 32'(bank[8'h12]), 32'hA5);

    issue_read(8'h34);
    wait_drain(2000);
    chk("err_after_read", 32'(err), 32'(exp_err));

    // Abandoned write frame: header and address only, then silence.
    push_byte(8'h57); push_byte(8'h10);
    wait_rx_empty();
    repeat (40) @(posedge clk);
    #1 chk("err_before_timeout", 32'(err), 32'd0);
    repeat (30) @(posedge clk);
    #1 chk("err_after_timeout", 32'(err), 32'd1);
    exp_err = 1'b1;
    issue_read(8'h10);
    wait_drain(2000);

    issue_bad(8'h41);
    issue_write(8'h77, 8'h3C);
    wait_drain(3000);
    chk("err_after_nak", 32'(err), 32'(exp_err));

    // Reset while the bridge waits for the data byte of a write frame.
    push_byte(8'h57); push_byte(8'h20);
    wait_rx_empty();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk_reset_values();
    @(negedge clk) rst = 1'b0;
    exp_err = 1'b0;
    repeat (80) @(posedge clk);
    chk("no_write_after_rst", 32'(bank[8'h20]), 32'(ref_regs[8'h20]));
    issue_write(8'h21, 8'h99);
    wait_drain(2000);
    chk("err_cleared_by_rst", 32'(err), 32'(exp_err));

    // Back-to-back random frames; later bytes queue up while replies are sent.
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(4, 0))
        0, 1: issue_write(8'($urandom), 8'($urandom));
        2, 3: issue_read(8'($urandom));
        default: begin
          c = 8'($urandom);
          while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
          issue_bad(c);
        end
      endcase
    end
    wait_drain(20000);
    chk("err_after_random", 32'(err), 32'(exp_err));
    chk("rx_clr_count", 32'(n_clr), 32'(n_pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
